// File: rtl/counter_pkg.sv
// Shared encodings and helpers for the up/down load counter family.
package counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Loads never place the counter above its terminal value.
    function automatic int unsigned clamp_load(input int unsigned value,
                                               input int unsigned max_val);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/counter_updown_load_tick_gen.sv
// Prescaler: turns enabled clock cycles into one count step every PRESCALE cycles.
module tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int unsigned PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

    logic [PC_W-1:0] r_pc;
    logic            w_step;

    assign w_step = en && (r_pc == PC_LAST);
    assign step   = w_step;

    // pc holds while en is low so the step phase is preserved across gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (clr) begin
            r_pc <= '0;
        end else if (en) begin
            r_pc <= w_step ? '0 : (r_pc + PC_W'(1));
        end
    end

endmodule

// File: rtl/counter_updown_load.sv
// General-purpose up/down event counter with constant/runtime load,
// wrap or saturate at the boundaries, prescaled enable and overflow flags.
module counter_updown_load
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 15,
    parameter int unsigned LOAD_VAL = 9,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             load_sel,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] LOAD_Q = WIDTH'(clamp_load(LOAD_VAL, MAX_VAL));

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_ovf;
    logic             w_step;
    logic             w_boundary;
    logic             w_wrap_evt;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_q_next;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .step(w_step)
    );

    assign w_boundary = (dir == DIR_UP) ? (r_q == MAX_Q) : (r_q == '0);
    assign w_wrap_evt = w_step && w_boundary && (sat_mode == MODE_WRAP);
    assign w_load_val = (load_sel == 1'b0) ? LOAD_Q
                                           : WIDTH'(clamp_load(32'(d), MAX_VAL));

    // Boundary handling keeps every next value inside 0..MAX_VAL.
    always_comb begin
        w_q_next = r_q;
        if (dir == DIR_UP) begin
            if (r_q != MAX_Q) begin
                w_q_next = r_q + WIDTH'(1);
            end else if (sat_mode == MODE_WRAP) begin
                w_q_next = '0;
            end
        end else begin
            if (r_q != '0) begin
                w_q_next = r_q - WIDTH'(1);
            end else if (sat_mode == MODE_WRAP) begin
                w_q_next = MAX_Q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_val;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_wrap <= w_wrap_evt;
            if (w_step) begin
                r_q <= w_q_next;
                if (w_boundary) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign q    = r_q;
    assign tc   = w_step && w_boundary;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_counter_updown_load.sv
// Directed bench for counter_updown_load: default, MAX_VAL=9 and PRESCALE=3 builds share stimulus.
module tb_counter_updown_load;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic       load_sel;
    logic [3:0] d;
    logic       dir;
    logic       sat_mode;

    logic [3:0] q_a, q_b, q_c;
    logic       tc_a, tc_b, tc_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       ovf_a, ovf_b, ovf_c;

    int n_cmp  = 0;
    int n_fail = 0;

    counter_updown_load dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_sel(load_sel), .d(d),
        .dir(dir), .sat_mode(sat_mode), .q(q_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    counter_updown_load #(.WIDTH(4), .MAX_VAL(9), .LOAD_VAL(9), .PRESCALE(1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_sel(load_sel), .d(d),
        .dir(dir), .sat_mode(sat_mode), .q(q_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
    );

    counter_updown_load #(.WIDTH(4), .MAX_VAL(15), .LOAD_VAL(9), .PRESCALE(3)) dut_c (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_sel(load_sel), .d(d),
        .dir(dir), .sat_mode(sat_mode), .q(q_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] val);
        load_sel = 1'b1;
        d        = val;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; load_sel = 1'b0; d = '0;
        dir = 1'b0; sat_mode = 1'b0;
        #1;
        n_cmp++;
        if (q_a !== 4'd0 || wrap_a !== 1'b0 || ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async q=%0d wrap=%0b ovf=%0b exp q=0 wrap=0 ovf=0", q_a, wrap_a, ovf_a);
        end
        en = 1'b1; load = 1'b1;
        tick();
        n_cmp++;
        if (q_a !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold q=%0d exp=0", q_a);
        end
        rst = 1'b0; en = 1'b0; load = 1'b1; load_sel = 1'b0;
        tick();
        load = 1'b0;
        n_cmp++;
        if (q_a !== 4'd9 || ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL load_const q=%0d ovf=%0b exp q=9 ovf=0", q_a, ovf_a);
        end
        n_cmp++;
        if (q_b !== 4'd9) begin
            n_fail++;
            $display("FAIL load_const_max9 q=%0d exp=9", q_b);
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_q[3]    = '{4'd15, 4'd0, 4'd1};
        logic       exp_tc[3]   = '{1'b1, 1'b0, 1'b0};
        logic       exp_wrap[3] = '{1'b0, 1'b1, 1'b0};
        logic       exp_ovf[3]  = '{1'b0, 1'b1, 1'b1};
        do_load(4'd14);
        n_cmp++;
        if (q_a !== 4'd14) begin
            n_fail++;
            $display("FAIL up_wrap_load q=%0d exp=14", q_a);
        end
        en = 1'b1; dir = 1'b0; sat_mode = 1'b0;
        #1;
        n_cmp++;
        if (tc_a !== 1'b0) begin
            n_fail++;
            $display("FAIL up_wrap_tc_at14 tc=%0b exp=0", tc_a);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (q_a !== exp_q[i] || tc_a !== exp_tc[i] || wrap_a !== exp_wrap[i] || ovf_a !== exp_ovf[i]) begin
                n_fail++;
                $display("FAIL up_wrap_cyc%0d q=%0d tc=%0b wrap=%0b ovf=%0b exp q=%0d tc=%0b wrap=%0b ovf=%0b",
                         i, q_a, tc_a, wrap_a, ovf_a, exp_q[i], exp_tc[i], exp_wrap[i], exp_ovf[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_down_sat();
        logic       exp_ovf[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        do_load(4'd1);
        dir = 1'b1; sat_mode = 1'b1; en = 1'b1;
        #1;
        n_cmp++;
        if (q_b !== 4'd1 || tc_b !== 1'b0) begin
            n_fail++;
            $display("FAIL down_sat_start q=%0d tc=%0b exp q=1 tc=0", q_b, tc_b);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (q_b !== 4'd0 || wrap_b !== 1'b0 || ovf_b !== exp_ovf[i] || tc_b !== 1'b1) begin
                n_fail++;
                $display("FAIL down_sat_cyc%0d q=%0d wrap=%0b ovf=%0b tc=%0b exp q=0 wrap=0 ovf=%0b tc=1",
                         i, q_b, wrap_b, ovf_b, tc_b, exp_ovf[i]);
            end
        end
    endtask

    task automatic test_clamp_priority();
        // dut_b holds q=0 with ovf=1 from the saturate test
        load_sel = 1'b1; d = 4'd13; load = 1'b1; en = 1'b1; dir = 1'b0;
        tick();
        load = 1'b0; en = 1'b0;
        n_cmp++;
        if (q_b !== 4'd9 || ovf_b !== 1'b0 || wrap_b !== 1'b0) begin
            n_fail++;
            $display("FAIL clamp_load q=%0d ovf=%0b wrap=%0b exp q=9 ovf=0 wrap=0", q_b, ovf_b, wrap_b);
        end
        n_cmp++;
        if (q_a !== 4'd13) begin
            n_fail++;
            $display("FAIL load_beats_count q=%0d exp=13", q_a);
        end
    endtask

    task automatic test_prescaler();
        logic [3:0] exp_q1[9] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3};
        logic       en_s2[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_q2[8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
        do_load(4'd0);
        dir = 1'b0; sat_mode = 1'b0; en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_cmp++;
            if (q_c !== exp_q1[i]) begin
                n_fail++;
                $display("FAIL prescale_run cyc%0d q=%0d exp=%0d", i, q_c, exp_q1[i]);
            end
        end
        en = 1'b0;
        do_load(4'd0);
        for (int i = 0; i < 8; i++) begin
            en = en_s2[i];
            tick();
            n_cmp++;
            if (q_c !== exp_q2[i]) begin
                n_fail++;
                $display("FAIL prescale_gap cyc%0d q=%0d exp=%0d", i, q_c, exp_q2[i]);
            end
        end
        en = 1'b0;
        // tc only when the step is due: down from 0 with pc at 0, then at 2
        do_load(4'd0);
        dir = 1'b1; en = 1'b1;
        #1;
        n_cmp++;
        if (tc_c !== 1'b0) begin
            n_fail++;
            $display("FAIL prescale_tc_nostep tc=%0b exp=0", tc_c);
        end
        tick();
        tick();
        n_cmp++;
        if (tc_c !== 1'b1 || q_c !== 4'd0) begin
            n_fail++;
            $display("FAIL prescale_tc_step tc=%0b q=%0d exp tc=1 q=0", tc_c, q_c);
        end
        tick();
        n_cmp++;
        if (q_c !== 4'd15 || wrap_c !== 1'b1 || ovf_c !== 1'b1) begin
            n_fail++;
            $display("FAIL prescale_down_wrap q=%0d wrap=%0b ovf=%0b exp q=15 wrap=1 ovf=1", q_c, wrap_c, ovf_c);
        end
        tick();
        n_cmp++;
        if (wrap_c !== 1'b0 || q_c !== 4'd15) begin
            n_fail++;
            $display("FAIL prescale_wrap_pulse wrap=%0b q=%0d exp wrap=0 q=15", wrap_c, q_c);
        end
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_async_reset();
        do_load(4'd15);
        dir = 1'b0; sat_mode = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        en = 1'b0;
        n_cmp++;
        if (q_a !== 4'd7 || ovf_a !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre q=%0d ovf=%0b exp q=7 ovf=1", q_a, ovf_a);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (q_a !== 4'd0 || ovf_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear q=%0d ovf=%0b exp q=0 ovf=0", q_a, ovf_a);
        end
        rst = 1'b0;
        en = 1'b1;
        tick();
        n_cmp++;
        if (q_a !== 4'd1) begin
            n_fail++;
            $display("FAIL async_resume q=%0d exp=1", q_a);
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        load_sel = 1'b1; d = 4'd3; load = 1'b1;
        tick();
        d = 4'd12;
        tick();
        load = 1'b0;
        n_cmp++;
        if (q_a !== 4'd12 || q_b !== 4'd9) begin
            n_fail++;
            $display("FAIL back_to_back_load q_a=%0d q_b=%0d exp q_a=12 q_b=9", q_a, q_b);
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_clamp_priority();
        test_prescaler();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
